cinit_seq_gen: RTL and testbench
================================

// Module: cinit_seq_gen
// PURPOSE
//  Self-sequencing NRS Gold-sequence seed generator for the NRS value generator chain.
//  One start walks every unmasked slot of a frame and every NRS symbol per slot.
//  Per (slot ns, symbol l) it emits cinit = 2^10*(7*(ns+1)+l+1)*(2*N_cell_ID+1) + 2*N_cell_ID + 1.
//  Multiplies with a shift-add datapath; output uses a valid/ready handshake to the Gold generator.
// PARAMETERS
//  WIDTH_ID  9   N_cell_ID width
//  WIDTH_A   8   width of A = 7*(ns+1)+l+1; also the multiply cycle count
//  WIDTH_P   18  product width, (WIDTH_A+WIDTH_ID+1) rounded to fit max product
//  N_SLOTS   20  slots per frame, <=32
//  SYM_FIRST 5   first NRS symbol index in a slot
//  SYM_LAST  6   last NRS symbol index in a slot, >= SYM_FIRST
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous active-low reset
//  start      in   1         begin frame walk; sampled in IDLE only
//  N_cell_ID  in   WIDTH_ID  cell ID; latched on accepted start
//  skip_mask  in   N_SLOTS   bit s=1 skips slot s; latched on accepted start (NB-IoT: bits 10,11)
//  ready      in   1         downstream accepts cinit
//  cinit      out  28        seed value
//  valid      out  1         cinit valid
//  slot       out  5         ns of current cinit
//  sym        out  3         l of current cinit
//  last       out  1         high with the final valid output of the frame
//  busy       out  1         high outside IDLE
//  done       out  1         one-cycle pulse when the frame walk ends
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal registers 0. Reset mid-walk aborts immediately, no done pulse.
//  FSM states: IDLE, FIND, LOAD, MUL, HOLD.
//   IDLE: start=1 -> latch N_cell_ID and skip_mask; slot=0; sym=SYM_FIRST; go to FIND.
//   FIND: one cycle per slot. Skip slots with skip_mask[slot]=1; unmasked slot -> LOAD.
//         slot==N_SLOTS -> done=1 for one cycle, go to IDLE. All masked: done 1 cycle after FIND ends, never valid.
//   LOAD: acc=0, operands A=7*(slot+1)+sym+1 and B=2*N_cell_ID+1 registered; cnt=0 -> MUL.
//   MUL: one bit of A per cycle, LSB first: if A[cnt] then acc+=B<<cnt; WIDTH_A cycles -> HOLD.
//   HOLD: cinit={acc,10'b0}+B; valid=1; slot/sym/last stable while ready=0.
//    valid&ready at edge H: valid=0 after H.
//    sym<SYM_LAST: sym+1 -> LOAD.
//    Else sym=SYM_FIRST, slot+1 -> FIND.
//  last=1 in HOLD iff sym==SYM_LAST and no unmasked slot remains above slot.
//   Precompute last in FIND/LOAD. Final handshake -> done pulse next cycle -> IDLE.
//  Latency for the first output of a slot: FIND cycles + 1 (LOAD) + WIDTH_A (MUL).
//   The next symbol of the same slot is valid WIDTH_A+1 edges after H.
//  start while busy=1 is ignored. Input changes after start have no effect.
//  Arithmetic: unsigned. B max 1023, A max 147; product < 2^18; cinit < 2^28, no overflow.
//   N_cell_ID > 503 is not clamped.
//  ready may be high before valid; the handshake counts only in HOLD.
// CONFIGURATION
//  CINIT_NCP_EN defined:
//   Adds input n_cp (1 bit), latched on start.
//   cinit={acc,10'b0}+2*N_cell_ID+n_cp, giving the LTE CRS seed form.
//  CINIT_NCP_EN undefined:
//   No n_cp port; the constant term is 2*N_cell_ID+1 (NRS form).
// TESTING
//  1 Reset/idle: rst=0 for 5 clks, then start=0 for 50 clks.
//    -> Required: valid=busy=done=0, cinit=0 throughout.
//  2 Basic: N_cell_ID=0, mask=0, ready=1, start pulse.
//    -> First cinit=13313 (ns0,l5), then 14337 (ns0,l6).
//    -> Then 40 outputs total; last on the 40th (ns19,l6); done one cycle later.
//  3 NB-IoT mask: N_cell_ID=503, mask bits 10,11 set, ready=1.
//    -> 36 outputs; slots 10/11 never appear.
//    -> Final cinit=151582703 (ns19,l6) with last=1.
//    -> Also check N_cell_ID=1 ns0 l5 = 39939.
//  4 Backpressure: ready=0 for 7 clks in HOLD.
//    -> valid, cinit, slot, sym stay stable; no output is lost or duplicated.
//    -> Next valid WIDTH_A+1 edges after the handshake.
//  5 All masked / ignored start: mask=20'hFFFFF.
//    -> done pulses with no valid.
//    -> Second start while busy: no restart, count unchanged.
//  6 Reset mid-walk: rst=0 during MUL of ns5.
//    -> Outputs 0 at once, no done pulse.
//    -> A fresh start restarts from ns0,l5.

Source files
------------

// File: rtl/cinit_seq_gen.sv
// Walks every unmasked slot/NRS symbol of a frame and emits Gold-sequence seeds via a shift-add multiplier.
// Optional feature macro: CINIT_NCP_EN (adds n_cp input, LTE CRS constant term 2*N_cell_ID+n_cp).
module cinit_seq_gen #(
  parameter int WIDTH_ID  = 9,
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_P   = 18,
  parameter int N_SLOTS   = 20,
  parameter int SYM_FIRST = 5,
  parameter int SYM_LAST  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef CINIT_NCP_EN
  input  logic                n_cp,
`endif
  input  logic [WIDTH_ID-1:0] N_cell_ID,
  input  logic [N_SLOTS-1:0]  skip_mask,
  input  logic                ready,
  output logic [27:0]         cinit,
  output logic                valid,
  output logic [4:0]          slot,
  output logic [2:0]          sym,
  output logic                last,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W  = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;
  localparam int SLOT_W = 6;

  typedef enum logic [2:0] {IDLE, FIND, LOAD, MUL, HOLD} state_t;

  state_t               state_reg;
  logic [WIDTH_ID-1:0]  id_reg;
  logic [N_SLOTS-1:0]   mask_reg;
  logic [SLOT_W-1:0]    slot_reg;
  logic [2:0]           sym_reg;
  logic [WIDTH_A-1:0]   a_reg;
  logic [WIDTH_ID:0]    b_reg;
  logic [WIDTH_P-1:0]   acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 last_pend_reg;
`ifdef CINIT_NCP_EN
  logic                 ncp_reg;
`endif

  logic [63:0]          mask_ext;
  logic [N_SLOTS-1:0]   unmasked_above;
  logic [WIDTH_A-1:0]   a_next;
  logic [WIDTH_P-1:0]   acc_next;
  logic [27:0]          konst;
  logic [27:0]          cinit_next;

  assign slot     = slot_reg[4:0];
  assign sym      = sym_reg;
  assign mask_ext = 64'(mask_reg);

  // Slots strictly above the current one that still need work; empty means this slot is the final one.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_above
    assign unmasked_above[gi] = !mask_reg[gi] && (slot_reg < SLOT_W'(gi));
  end

  assign a_next   = WIDTH_A'(7 * (int'(slot_reg) + 1) + int'(sym_reg) + 1);
  assign acc_next = acc_reg + (a_reg[cnt_reg] ? (WIDTH_P'(b_reg) << cnt_reg) : WIDTH_P'(0));

`ifdef CINIT_NCP_EN
  assign konst = 28'({id_reg, 1'b0}) + 28'(ncp_reg);
`else
  assign konst = 28'(b_reg);
`endif

  assign cinit_next = 28'({acc_next, 10'b0}) + konst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      id_reg        <= '0;
      mask_reg      <= '0;
      slot_reg      <= '0;
      sym_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      last_pend_reg <= 1'b0;
`ifdef CINIT_NCP_EN
      ncp_reg       <= 1'b0;
`endif
      cinit         <= '0;
      valid         <= 1'b0;
      last          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            id_reg    <= N_cell_ID;
            mask_reg  <= skip_mask;
`ifdef CINIT_NCP_EN
            ncp_reg   <= n_cp;
`endif
            slot_reg  <= '0;
            sym_reg   <= 3'(SYM_FIRST);
            busy      <= 1'b1;
            state_reg <= FIND;
          end
        end
        FIND: begin
          if (slot_reg == SLOT_W'(N_SLOTS)) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else if (mask_ext[slot_reg]) begin
            slot_reg <= slot_reg + 1'b1;
          end else begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          acc_reg       <= '0;
          a_reg         <= a_next;
          b_reg         <= {id_reg, 1'b1};
          cnt_reg       <= '0;
          last_pend_reg <= (sym_reg == 3'(SYM_LAST)) && !(|unmasked_above);
          state_reg     <= MUL;
        end
        MUL: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH_A - 1)) begin
            cinit     <= cinit_next;
            valid     <= 1'b1;
            last      <= last_pend_reg;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
            cinit <= '0;
            if (last) begin
              // Nothing left to emit, so finish without revisiting trailing masked slots.
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else if (sym_reg < 3'(SYM_LAST)) begin
              sym_reg   <= sym_reg + 1'b1;
              state_reg <= LOAD;
            end else begin
              sym_reg   <= 3'(SYM_FIRST);
              slot_reg  <= slot_reg + 1'b1;
              state_reg <= FIND;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cinit_seq_gen.sv
// Randomized bench for cinit_seq_gen: a per-frame list of expected seeds is built from the closed-form
// formula and compared cycle by cycle, including latency, stalls, done pulse and mid-walk reset.
module tb_cinit_seq_gen;

  localparam int WIDTH_ID  = 9;
  localparam int WIDTH_A   = 8;
  localparam int WIDTH_P   = 18;
  localparam int N_SLOTS   = 20;
  localparam int SYM_FIRST = 5;
  localparam int SYM_LAST  = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                ready = 1'b0;
  logic [WIDTH_ID-1:0] N_cell_ID = '0;
  logic [N_SLOTS-1:0]  skip_mask = '0;
`ifdef CINIT_NCP_EN
  logic                n_cp = 1'b0;
`endif
  logic [27:0]         cinit;
  logic                valid;
  logic [4:0]          slot;
  logic [2:0]          sym;
  logic                last;
  logic                busy;
  logic                done;

  cinit_seq_gen #(
    .WIDTH_ID(WIDTH_ID), .WIDTH_A(WIDTH_A), .WIDTH_P(WIDTH_P),
    .N_SLOTS(N_SLOTS), .SYM_FIRST(SYM_FIRST), .SYM_LAST(SYM_LAST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef CINIT_NCP_EN
    .n_cp(n_cp),
`endif
    .N_cell_ID(N_cell_ID),
    .skip_mask(skip_mask),
    .ready(ready),
    .cinit(cinit),
    .valid(valid),
    .slot(slot),
    .sym(sym),
    .last(last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int     slot;
    int     sym;
    longint cinit;
    bit     last;
  } item_t;

  item_t exp_q[$];

  // Expected output list straight from the seed formula, in walk order.
  task automatic build_model(input int id, input logic [N_SLOTS-1:0] mask, input int ncp);
    int last_slot;
    longint kterm;
    item_t it;
    exp_q.delete();
    last_slot = -1;
    for (int s = 0; s < N_SLOTS; s++) if (!mask[s]) last_slot = s;
`ifdef CINIT_NCP_EN
    kterm = 2 * id + ncp;
`else
    kterm = 2 * id + 1 + 0 * ncp;
`endif
    for (int s = 0; s < N_SLOTS; s++) begin
      if (mask[s]) continue;
      for (int l = SYM_FIRST; l <= SYM_LAST; l++) begin
        it.slot  = s;
        it.sym   = l;
        it.cinit = longint'(7 * (s + 1) + l + 1) * longint'(2 * id + 1) * 1024 + kterm;
        it.last  = (s == last_slot) && (l == SYM_LAST);
        exp_q.push_back(it);
      end
    end
  endtask

  // rdy_pct < 0 selects "hold ready low for 7 cycles of every HOLD".
  task automatic run_frame(input int id, input logic [N_SLOTS-1:0] mask, input int rdy_pct,
                           input bit dup_start, input int abort_slot,
                           output int n_out, output longint first_c, output longint final_c);
    int t, ref_t, prev_slot, done_t, hold_cnt, abort_t, exp_gap, ncp;
    bit was_valid, finished, aborted;
    item_t it;
`ifdef CINIT_NCP_EN
    ncp = int'($urandom_range(1));
`else
    ncp = 1;
`endif
    build_model(id, mask, ncp);
    n_out = 0; first_c = -1; final_c = -1;
    @(negedge clk);
    N_cell_ID = WIDTH_ID'(id);
    skip_mask = mask;
`ifdef CINIT_NCP_EN
    n_cp = ncp[0];
`endif
    start = 1'b1;
    t = 0; ref_t = 0; prev_slot = -1; hold_cnt = 0; abort_t = -1;
    done_t = (exp_q.size() == 0) ? N_SLOTS + 2 : -1;
    was_valid = 1'b0; finished = 1'b0; aborted = 1'b0;
    while (!finished && t < 3000) begin
      @(negedge clk);
      t++;
      start = dup_start && (t == 3);
      if (t == 1) begin
        N_cell_ID = WIDTH_ID'($urandom);
        skip_mask = N_SLOTS'($urandom);
`ifdef CINIT_NCP_EN
        n_cp = 1'($urandom);
`endif
      end
      if (t == abort_t) begin
        rst = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cinit", cinit, 0);
        check("rst_slot", slot, 0);
        check("rst_sym", sym, 0);
        check("rst_last", last, 0);
        repeat (3) begin
          @(negedge clk);
          check("rst_no_done", done, 0);
          check("rst_no_busy", busy, 0);
        end
        rst = 1'b1;
        aborted = 1'b1;
        finished = 1'b1;
      end else begin
        check("done", done, (t == done_t));
        check("busy", busy, (done_t < 0) || (t < done_t));
        if (valid) begin
          hold_cnt++;
          if (exp_q.size() == 0) begin
            check("extra_valid", valid, 0);
          end else begin
            it = exp_q[0];
            if (!was_valid) begin
              exp_gap = (it.slot == prev_slot) ? WIDTH_A + 2 : it.slot - prev_slot + WIDTH_A + 2;
              check("latency", t - ref_t, exp_gap);
            end
            check("cinit", cinit, it.cinit);
            check("slot", slot, it.slot);
            check("sym", sym, it.sym);
            check("last", last, it.last);
          end
        end
        if (rdy_pct < 0) ready = valid && (hold_cnt >= 8);
        else             ready = (int'($urandom_range(99)) < rdy_pct);
        if (valid && ready && exp_q.size() > 0) begin
          it = exp_q.pop_front();
          $display("tx %0d: slot=%0d sym=%0d cinit=%0d last=%0d", n_out, it.slot, it.sym, cinit, last);
          if (n_out == 0) first_c = longint'(cinit);
          n_out++;
          prev_slot = it.slot;
          ref_t = t;
          hold_cnt = 0;
          if (it.last) begin
            done_t = t + 1;
            final_c = longint'(cinit);
          end
          if (abort_slot >= 0 && it.slot == abort_slot && it.sym == SYM_FIRST) abort_t = t + 3;
        end
        was_valid = valid && !ready;
        if (done_t >= 0 && t >= done_t) finished = 1'b1;
      end
    end
    start = 1'b0;
    ready = 1'b0;
    if (!finished) check("timeout", 1, 0);
    if (!aborted) begin
      check("leftover", exp_q.size(), 0);
      @(negedge clk);
      check("done_width", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int n;
    longint fc, lc;
    int rid, rpct;
    logic [N_SLOTS-1:0] rmask;

    // Reset held, then idle with no start.
    repeat (5) begin
      @(negedge clk);
      check("reset_valid", valid, 0);
      check("reset_busy", busy, 0);
      check("reset_cinit", cinit, 0);
    end
    rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("idle_valid", valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_cinit", cinit, 0);
    end

    run_frame(0, '0, 100, 1'b0, -1, n, fc, lc);
    check("basic_count", n, 40);
    check("basic_first", fc, 13313);
    check("basic_final", lc, 150529);

    run_frame(503, 20'h00C00, 100, 1'b0, -1, n, fc, lc);
    check("nbiot_count", n, 36);
    check("nbiot_final", lc, 151582703);

    run_frame(1, '0, 100, 1'b0, -1, n, fc, lc);
    check("id1_first", fc, 39939);

    run_frame(int'($urandom_range(511)), N_SLOTS'($urandom) & N_SLOTS'($urandom), -1, 1'b0, -1, n, fc, lc);

    run_frame(42, 20'hFFFFF, 100, 1'b1, -1, n, fc, lc);
    check("masked_count", n, 0);

    run_frame(300, 20'h80001, 100, 1'b1, -1, n, fc, lc);
    check("dup_start_count", n, 36);

    run_frame(77, '0, 100, 1'b0, 5, n, fc, lc);
    check("abort_count", n, 11);
    run_frame(77, '0, 100, 1'b0, -1, n, fc, lc);
    check("restart_first", fc, longint'(13) * 155 * 1024 + 155);

    for (int k = 0; k < 6; k++) begin
      rid   = int'($urandom_range(511));
      rmask = N_SLOTS'($urandom) & N_SLOTS'($urandom);
      rpct  = int'($urandom_range(100, 30));
      run_frame(rid, rmask, rpct, 1'b0, -1, n, fc, lc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
